// File: rtl/nv_nvdla_cdma_wt_arb_pkg.sv
// Shared types and constants for the CDMA weight-fifo write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nv_nvdla_cdma_wt_arb_pkg;

    localparam int ARB_DW    = 6;
    localparam int ARB_DEPTH = 128;
    localparam int ARB_CW    = 8;

    // Requester indices; rr_last holds one of these.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/nv_nvdla_cdma_wt_occ_cnt.sv
// Up/down occupancy counter fed by observed fifo push/pop handshakes.
// Latency: count reflects a push/pop on the clock edge after it happens.
// Backpressure: none; saturates (holds) at 0 and at all-ones, flagged by assertion.
module nv_nvdla_cdma_wt_occ_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: push and pop together cancel; out-of-range steps are dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

    // A pop with nothing tracked or a push past the counter range means the
    // fifo and this counter have lost sync.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_)
        !(dec_i && !inc_i && (cnt_q == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_)
        !(inc_i && !dec_i && (cnt_q == CNT_MAX)));

endmodule

// File: rtl/nv_nvdla_cdma_wt_fifo_arb.sv
// Packet-locked round-robin arbiter for the weight fifo write port, with prefetch headroom limit.
// Latency: zero-cycle combinational grant/mux; state and occupancy update on the next edge.
// Backpressure: fifo_wr_ready goes straight to the granted requester's ready; the other sees 0.
module nv_nvdla_cdma_wt_fifo_arb
    import nv_nvdla_cdma_wt_arb_pkg::*;
#(
    parameter int DW    = ARB_DW,
    parameter int DEPTH = ARB_DEPTH,
    parameter int CW    = ARB_CW
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic          req0_last,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    input  logic          req1_last,
    output logic          fifo_wr_req,
    input  logic          fifo_wr_ready,
    output logic [DW-1:0] fifo_wr_data,
    input  logic          fifo_rd_req,
    input  logic          fifo_rd_ready,
    input  logic [CW-1:0] cfg_req1_limit,
    output logic [CW-1:0] occ,
    output logic          arb_idle
);

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic          rr_last_q;
    logic          rr_last_d;
    logic [CW-1:0] occ_q;

    logic          elig0;
    logic          elig1;
    logic          gnt_vld;
    logic          gnt_idx;
    logic          sel_valid;
    logic          sel_last;
    logic          push;
    logic          pop;

    // Prefetch may only open a packet while tracked occupancy sits below its limit.
    assign elig0 = req0_valid;
    assign elig1 = req1_valid && ((cfg_req1_limit == '0) || (occ_q < cfg_req1_limit));

    // Grant selection: round-robin in IDLE, fixed to the owner while locked.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = REQ0;
        case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
                    gnt_vld = 1'b1;
                    gnt_idx = ~rr_last_q;
                end else if (elig0) begin
                    gnt_vld = 1'b1;
                    gnt_idx = REQ0;
                end else if (elig1) begin
                    gnt_vld = 1'b1;
                    gnt_idx = REQ1;
                end
            end
            LOCK0: begin
                gnt_vld = 1'b1;
                gnt_idx = REQ0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt_idx = REQ1;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_idx = REQ0;
            end
        endcase
    end

    assign sel_valid = gnt_vld && ((gnt_idx == REQ1) ? req1_valid : req0_valid);
    assign sel_last  = (gnt_idx == REQ1) ? req1_last : req0_last;

    assign fifo_wr_req  = sel_valid;
    assign fifo_wr_data = !gnt_vld ? '0 : ((gnt_idx == REQ1) ? req1_data : req0_data);
    assign req0_ready   = gnt_vld && (gnt_idx == REQ0) && fifo_wr_ready;
    assign req1_ready   = gnt_vld && (gnt_idx == REQ1) && fifo_wr_ready;

    assign push = fifo_wr_req && fifo_wr_ready;
    assign pop  = fifo_rd_req && fifo_rd_ready;

    // Next state: a non-last first beat locks the grant; the last beat releases it
    // and records the owner so the other side wins the next tie.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    if (sel_last) begin
                        rr_last_d = gnt_idx;
                    end else begin
                        state_d = (gnt_idx == REQ1) ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0: begin
                if (push && sel_last) begin
                    state_d   = IDLE;
                    rr_last_d = REQ0;
                end
            end
            LOCK1: begin
                if (push && sel_last) begin
                    state_d   = IDLE;
                    rr_last_d = REQ1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and round-robin pointer; reset favours requester 0 on the first tie.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IDLE;
            rr_last_q <= REQ1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    nv_nvdla_cdma_wt_occ_cnt #(
        .CW (CW)
    ) u_occ_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .inc_i  (push),
        .dec_i  (pop),
        .cnt_o  (occ_q)
    );

    assign occ      = occ_q;
    assign arb_idle = (state_q == IDLE) && (occ_q == '0);

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_fifo_arb.sv
// Scoreboard bench for the weight-fifo write-port arbiter.
// Latency: directed cycle vectors; pushes are checked on the falling edge.
// Backpressure: fifo_wr_ready is driven per vector to exercise stalls.
module tb_nv_nvdla_cdma_wt_fifo_arb;

    localparam int DW = 6;
    localparam int CW = 8;

    logic          clk;
    logic          reset_;
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_data;
    logic          req0_last;
    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_data;
    logic          req1_last;
    logic          fifo_wr_req;
    logic          fifo_wr_ready;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_rd_req;
    logic          fifo_rd_ready;
    logic [CW-1:0] cfg_req1_limit;
    logic [CW-1:0] occ;
    logic          arb_idle;

    int n_cmp;
    int n_err;
    logic [DW-1:0] exp_q[$];

    nv_nvdla_cdma_wt_fifo_arb dut (
        .clk            (clk),
        .reset_         (reset_),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_data      (req0_data),
        .req0_last      (req0_last),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_data      (req1_data),
        .req1_last      (req1_last),
        .fifo_wr_req    (fifo_wr_req),
        .fifo_wr_ready  (fifo_wr_ready),
        .fifo_wr_data   (fifo_wr_data),
        .fifo_rd_req    (fifo_rd_req),
        .fifo_rd_ready  (fifo_rd_ready),
        .cfg_req1_limit (cfg_req1_limit),
        .occ            (occ),
        .arb_idle       (arb_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted push must match the oldest expected beat.
    always @(negedge clk) begin
        if (reset_ && fifo_wr_req && fifo_wr_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL push_unexpected: got data %0h, expected no push (t=%0t)", fifo_wr_data, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (fifo_wr_data !== e) begin
                    n_err++;
                    $display("FAIL push_data: got %0h, expected %0h (t=%0t)", fifo_wr_data, e, $time);
                end
            end
        end
    end

    // One cycle of stimulus, called just after a rising edge.
    // g: 0/1 = requester that must hold the grant, 2 = no grant.
    // eocc: occupancy expected during this cycle (before its own push/pop).
    task automatic cyc(input logic v0, input logic [DW-1:0] d0, input logic l0,
                       input logic v1, input logic [DW-1:0] d1, input logic l1,
                       input logic wr, input logic pp, input int g, input int eocc);
        logic          ev;
        logic [DW-1:0] ed;
        req0_valid    = v0;
        req0_data     = d0;
        req0_last     = l0;
        req1_valid    = v1;
        req1_data     = d1;
        req1_last     = l1;
        fifo_wr_ready = wr;
        fifo_rd_req   = pp;
        fifo_rd_ready = pp;
        ev = (g == 0) ? v0 : (g == 1) ? v1 : 1'b0;
        ed = (g == 0) ? d0 : (g == 1) ? d1 : '0;
        if (ev && wr) exp_q.push_back(ed);
        @(negedge clk);
        chk("req0_ready", int'(req0_ready), int'((g == 0) && wr));
        chk("req1_ready", int'(req1_ready), int'((g == 1) && wr));
        chk("fifo_wr_req", int'(fifo_wr_req), int'(ev));
        chk("fifo_wr_data", int'(fifo_wr_data), int'(ed));
        chk("occ", int'(occ), eocc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic pp, input int eocc);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, pp, 2, eocc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_ = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
        fifo_wr_ready = 1'b0; fifo_rd_req = 1'b0; fifo_rd_ready = 1'b0;
        cfg_req1_limit = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_req", int'(fifo_wr_req), 0);
        chk("rst_req0_ready", int'(req0_ready), 0);
        chk("rst_req1_ready", int'(req1_ready), 0);
        chk("rst_wr_data", int'(fifo_wr_data), 0);
        chk("rst_occ", int'(occ), 0);
        chk("rst_arb_idle", int'(arb_idle), 1);
        reset_ = 1'b1;

        // Single-beat packets from both sides alternate 0,1,0,1.
        cyc(1, 6'h01, 1, 1, 6'h21, 1, 1, 0, 0, 0);
        cyc(1, 6'h02, 1, 1, 6'h21, 1, 1, 0, 1, 1);
        cyc(1, 6'h02, 1, 1, 6'h22, 1, 1, 0, 0, 2);
        cyc(1, 6'h03, 1, 1, 6'h22, 1, 1, 0, 1, 3);
        chk("t1_arb_idle", int'(arb_idle), 0);
        idle_cyc(0, 4);

        // req0 3-beat packet with req1 waiting, including a stall inside LOCK0.
        cyc(1, 6'h04, 0, 1, 6'h23, 1, 1, 0, 0, 4);
        cyc(1, 6'h05, 0, 1, 6'h23, 1, 1, 0, 0, 5);
        cyc(0, 6'h05, 0, 1, 6'h23, 1, 1, 0, 0, 6);
        cyc(1, 6'h06, 1, 1, 6'h23, 1, 1, 0, 0, 6);
        // rr_last is now 0, so the tie goes to req1, then back to req0.
        cyc(1, 6'h07, 1, 1, 6'h23, 1, 1, 0, 1, 7);
        cyc(1, 6'h07, 1, 1, 6'h24, 1, 1, 0, 0, 8);

        // Drain to occ=4.
        idle_cyc(1, 9);
        idle_cyc(1, 8);
        idle_cyc(1, 7);
        idle_cyc(1, 6);
        idle_cyc(1, 5);

        // Limit 4 blocks req1 at occ=4; after a pop it starts a 5-beat packet.
        cfg_req1_limit = 8'd4;
        cyc(0, 6'h00, 0, 1, 6'h30, 0, 1, 0, 2, 4);
        cyc(0, 6'h00, 0, 1, 6'h30, 0, 1, 1, 2, 4);
        cyc(0, 6'h00, 0, 1, 6'h30, 0, 1, 0, 1, 3);
        cyc(0, 6'h00, 0, 1, 6'h31, 0, 1, 0, 1, 4);
        cyc(1, 6'h08, 1, 1, 6'h32, 0, 1, 0, 1, 5);
        cyc(1, 6'h08, 1, 1, 6'h33, 0, 1, 0, 1, 6);
        cyc(1, 6'h08, 1, 1, 6'h34, 1, 1, 0, 1, 7);
        idle_cyc(0, 8);
        cfg_req1_limit = 8'd0;

        // fifo_wr_ready low inside LOCK0 holds the beat and the grant.
        cyc(1, 6'h09, 0, 1, 6'h25, 1, 1, 0, 0, 8);
        cyc(1, 6'h0A, 0, 1, 6'h25, 1, 0, 0, 0, 9);
        cyc(1, 6'h0A, 0, 1, 6'h25, 1, 1, 0, 0, 9);
        cyc(1, 6'h0B, 1, 1, 6'h25, 1, 1, 0, 0, 10);

        // Push and pop together at occ=10 leave it at 10.
        idle_cyc(1, 11);
        cyc(1, 6'h0C, 1, 0, 6'h00, 0, 1, 1, 0, 10);
        idle_cyc(0, 10);

        // Reset in the middle of a req1 packet.
        cyc(0, 6'h00, 0, 1, 6'h26, 0, 1, 0, 1, 10);
        cyc(0, 6'h00, 0, 1, 6'h27, 0, 1, 0, 1, 11);
        reset_ = 1'b0;
        req1_valid = 1'b0;
        req1_data = '0;
        #2;
        chk("rst2_occ", int'(occ), 0);
        chk("rst2_arb_idle", int'(arb_idle), 1);
        chk("rst2_wr_req", int'(fifo_wr_req), 0);
        @(posedge clk);
        #1;
        reset_ = 1'b1;
        // Back in IDLE with rr_last reset: req0 wins the tie.
        cyc(1, 6'h0D, 1, 1, 6'h28, 1, 1, 0, 0, 0);
        idle_cyc(0, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cdma_wt_fifo_arb.md
# nv_nvdla_cdma_wt_fifo_arb

Packet-level round-robin arbiter sharing the write port of the CDMA weight-path fifo (6-bit entries, 128 deep, valid/ready) between two requesters. Requester 0 carries demand weight requests. Requester 1 carries prefetch requests. The block locks the grant for the length of a packet, so packets never interleave. It keeps its own occupancy count from observed pushes and pops, and uses it to stop requester 1 from starting packets above a programmable limit, which reserves headroom for requester 0.

## Interface
Parameters:
- DW, 6, entry data width
- DEPTH, 128, fifo depth (informational; sizes CW)
- CW, 8, occupancy/limit counter width

Ports:
- clk  in  1  core clock
- reset_  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 beat valid
- req0_ready  out  1  requester 0 beat accepted when valid&&ready
- req0_data  in  DW  requester 0 beat data
- req0_last  in  1  last beat of requester 0 packet
- req1_valid / req1_ready / req1_data / req1_last  same as req0, requester 1
- fifo_wr_req  out  1  push request to fifo
- fifo_wr_ready  in  1  fifo can accept
- fifo_wr_data  out  DW  push data
- fifo_rd_req  in  1  fifo output valid (observed only)
- fifo_rd_ready  in  1  consumer ready (observed only)
- cfg_req1_limit  in  CW  requester 1 start threshold; 0 = unlimited
- occ  out  CW  current occupancy count
- arb_idle  out  1  state==IDLE and occ==0

## Operation
- push = fifo_wr_req && fifo_wr_ready. pop = fifo_rd_req && fifo_rd_ready.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - elig0 = req0_valid.
  - elig1 = req1_valid && (cfg_req1_limit==0 || occ < cfg_req1_limit).
  - Both eligible: grant goes to the requester opposite rr_last. One eligible: grant goes to it. Neither: no grant.
  - First-beat transfer happens in the same cycle.
  - On push of the granted requester: last=1 keeps IDLE and sets rr_last=grantee. last=0 moves to LOCKn.
- LOCKn: grant fixed to n with no eligibility re-check; the packet is never split by the limit.
  - On push with reqn_last=1: go to IDLE and set rr_last=n.
  - reqn_valid low inside LOCKn stalls; the other requester is never granted.
- fifo_wr_req = valid of granted requester. fifo_wr_data = data of granted requester (0 when no grant).
- reqn_ready = granted(n) && fifo_wr_ready. The non-granted ready is 0.
- occ:
  - +1 on push only, -1 on pop only, unchanged when both or neither occur.
  - Legal range 0..DEPTH+1, because the fifo input register holds one extra entry.
  - Pop at occ==0 or push at occ==2^CW-1: count holds. This is a simulation assertion failure.
- cfg_req1_limit is sampled only at packet start in IDLE. A change mid-packet affects the next arbitration.

## Timing
- Reset values: state=IDLE, rr_last=1 (requester 0 wins the first tie), occ=0. Outputs: fifo_wr_req=0, req0_ready=0, req1_ready=0, fifo_wr_data=0, arb_idle=1.
- Combinational paths: reqn_valid/data to fifo_wr_req/data, and fifo_wr_ready to reqn_ready. Zero-cycle latency.
- All state (FSM, rr_last, occ) updates on the clk edge after the push/pop cycle. occ reflects a push one cycle later.
- Eligibility uses registered occ, not same-cycle push/pop.
- Reset asserted mid-packet: immediate return to IDLE with occ=0. The upstream and the fifo must be reset together.
- Back-to-back single-beat packets from both requesters alternate every cycle while fifo_wr_ready=1.

## Structure
- Package nv_nvdla_cdma_wt_arb_pkg holds:
  - the state enum (IDLE/LOCK0/LOCK1)
  - DW/DEPTH/CW defaults
  - the requester index constants
- Sub-module nv_nvdla_cdma_wt_occ_cnt: up/down occupancy counter with hold-on-both, underflow/overflow assertions, and async active-low reset.
- Arbiter FSM and muxing stay in the top module.

## Test plan
- Reset, then both valid, single-beat, fifo_wr_ready=1 for 4 cycles. Required: grants 0,1,0,1; occ reaches 4; arb_idle=0.
- req0 3-beat packet starts with req1 valid throughout. Required: req1_ready=0 for 3 cycles, req1 granted on cycle 4, rr_last=0 after the packet.
- cfg_req1_limit=4, occ=4, only req1 valid. Required: no grant. A pop drops occ to 3, and req1 is granted the next cycle.
- req1 starts a 5-beat packet at occ=3 with limit 4. Required: all 5 beats transfer; occ=8 with no pops.
- fifo_wr_ready=0 mid-LOCK0. Required: req0_ready=0, state holds LOCK0, no data change on fifo_wr_data while req0_data is stable.
- Push and pop in the same cycle at occ=10. Required: occ stays 10. Reset pulse mid-LOCK1 returns state to IDLE with occ=0.
